adder_measure_sequencer: RTL and testbench

ADDER_MEASURE_SEQUENCER -- requirements
Module: adder_measure_sequencer

---
 rtl/adder_measure_pkg.sv | 17 +
 rtl/adder_measure_sequencer_if.sv | 24 ++
 rtl/onehot_low_decode.sv | 22 ++
 rtl/adder_measure_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_adder_measure_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/adder_measure_pkg.sv
// Shared state encoding and default parameter values for the adder ring-oscillator
// measurement sequencer.
package adder_measure_pkg;

  localparam int DEF_WIDTH                 = 8;
  localparam int DEF_TIME_COUNTER_BITS     = 32;
  localparam int DEF_RING_OSC_COUNTER_BITS = 32;
  localparam int DEF_SETTLE_CYCLES         = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;
  localparam logic [2:0] ST_EMIT   = 3'd5;

endpackage

// File: rtl/adder_measure_sequencer_if.sv
// Result stream of the measurement sequencer: one valid/ready beat per measured step.
interface adder_measure_sequencer_if
  import adder_measure_pkg::*;
#(
  parameter int WIDTH                 = DEF_WIDTH,
  parameter int RING_OSC_COUNTER_BITS = DEF_RING_OSC_COUNTER_BITS
);
  logic                             res_valid;
  logic                             res_ready;
  logic                             res_bypass;
  logic [$clog2(WIDTH)-1:0]         res_bit;
  logic [RING_OSC_COUNTER_BITS-1:0] res_count;
  logic                             res_last;

  modport master (
    output res_valid, res_bypass, res_bit, res_count, res_last,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_bypass, res_bit, res_count, res_last,
    output res_ready
  );
endinterface

// File: rtl/onehot_low_decode.sv
// Index to active-low one-hot vector; all ones when not enabled.
module onehot_low_decode #(
  parameter int WIDTH = 8
) (
  input  logic [$clog2(WIDTH)-1:0] idx,
  input  logic                     en,
  output logic [WIDTH-1:0]         vec_b
);
  localparam int IW = $clog2(WIDTH);

  // decode one selected bit low
  always_comb begin
    vec_b = {WIDTH{1'b1}};
    for (int i = 0; i < WIDTH; i++) begin
      if (en && (idx == IW'(i))) begin
        vec_b[i] = 1'b0;
      end else begin
        vec_b[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_measure_sequencer.sv
// Steps an adder ring oscillator through a bypass calibration and per-bit paths,
// capturing the ring count for each step and streaming it out.
module adder_measure_sequencer
  import adder_measure_pkg::*;
#(
  parameter int WIDTH                 = DEF_WIDTH,
  parameter int TIME_COUNTER_BITS     = DEF_TIME_COUNTER_BITS,
  parameter int RING_OSC_COUNTER_BITS = DEF_RING_OSC_COUNTER_BITS,
  parameter int SETTLE_CYCLES         = DEF_SETTLE_CYCLES
) (
  input  logic                             clk,
  input  logic                             reset_b,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             sweep,
  input  logic                             cal,
  input  logic [$clog2(WIDTH)-1:0]         bit_sel,
  input  logic [TIME_COUNTER_BITS-1:0]     integ_time,
  output logic                             adder_reset,
  output logic                             stop_b,
  output logic                             bypass_b,
  output logic                             counter_load,
  output logic                             counter_enable,
  output logic [WIDTH-1:0]                 a_input_ring_bit_b,
  output logic [WIDTH-1:0]                 s_output_bit_b,
  input  logic                             done,
  input  logic [RING_OSC_COUNTER_BITS-1:0] ring_osc_counter,
  adder_measure_sequencer_if.master        res,
  output logic                             busy,
  output logic                             err
);
  localparam int BSW = $clog2(WIDTH);
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);

  logic [2:0]                       state_r, state_nxt_s;
  logic                             step_byp_r, step_byp_nxt_s;
  logic [BSW-1:0]                   step_bit_r, step_bit_nxt_s;
  logic                             sweep_r, cal_r;
  logic [BSW-1:0]                   bit_sel_r;
  logic [TIME_COUNTER_BITS-1:0]     integ_time_r;
  logic                             run_seen_r;
  logic [SCW-1:0]                   settle_cnt_r;
  logic                             res_valid_r, res_bypass_r, res_last_r;
  logic [BSW-1:0]                   res_bit_r;
  logic [RING_OSC_COUNTER_BITS-1:0] res_count_r;
  logic                             adder_reset_r, stop_b_r, bypass_b_r;
  logic                             counter_load_r, counter_enable_r, busy_r, err_r;
  logic [WIDTH-1:0]                 a_vec_r, s_vec_r, a_vec_s, s_vec_s;
  logic                             accept_s, is_last_s, settle_done_s, active_nxt_s;
  logic                             unused_s;

  assign accept_s      = start && (integ_time != {TIME_COUNTER_BITS{1'b0}})
                         && (sweep || (32'(bit_sel) < 32'(WIDTH)));
  assign is_last_s     = !step_byp_r && (!sweep_r || (step_bit_r == BSW'(WIDTH - 1)));
  assign settle_done_s = (settle_cnt_r == SCW'(SETTLE_CYCLES - 1));
  assign active_nxt_s  = (state_nxt_s == ST_CLEAR) || (state_nxt_s == ST_LOAD)
                         || (state_nxt_s == ST_RUN) || (state_nxt_s == ST_SETTLE);
  // integration time is held for the external timer; nothing in here consumes it
  assign unused_s      = ^integ_time_r;

  // next state and step selection; abort overrides every other transition
  always_comb begin
    state_nxt_s    = state_r;
    step_byp_nxt_s = step_byp_r;
    step_bit_nxt_s = step_bit_r;
    if (abort && (state_r != ST_IDLE)) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_nxt_s    = ST_CLEAR;
            step_byp_nxt_s = cal;
            step_bit_nxt_s = sweep ? {BSW{1'b0}} : bit_sel;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CLEAR: state_nxt_s = ST_LOAD;
        ST_LOAD:  state_nxt_s = ST_RUN;
        ST_RUN: begin
          if (run_seen_r && done) begin
            state_nxt_s = ST_SETTLE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_SETTLE: begin
          if (settle_done_s) begin
            state_nxt_s = ST_EMIT;
          end else begin
            state_nxt_s = ST_SETTLE;
          end
        end
        ST_EMIT: begin
          if (!res.res_ready) begin
            state_nxt_s = ST_EMIT;
          end else if (res_last_r) begin
            state_nxt_s = ST_IDLE;
          end else if (step_byp_r) begin
            state_nxt_s    = ST_CLEAR;
            step_byp_nxt_s = 1'b0;
            step_bit_nxt_s = sweep_r ? {BSW{1'b0}} : bit_sel_r;
          end else begin
            state_nxt_s    = ST_CLEAR;
            step_bit_nxt_s = step_bit_r + BSW'(1);
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  onehot_low_decode #(.WIDTH(WIDTH)) u_a_dec (
    .idx(step_bit_nxt_s), .en(active_nxt_s && !step_byp_nxt_s), .vec_b(a_vec_s)
  );
  onehot_low_decode #(.WIDTH(WIDTH)) u_s_dec (
    .idx(step_bit_nxt_s), .en(active_nxt_s && !step_byp_nxt_s), .vec_b(s_vec_s)
  );

  // sequencing state, latched run configuration and result capture
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_r      <= ST_IDLE;
      step_byp_r   <= 1'b0;
      step_bit_r   <= {BSW{1'b0}};
      sweep_r      <= 1'b0;
      cal_r        <= 1'b0;
      bit_sel_r    <= {BSW{1'b0}};
      integ_time_r <= {TIME_COUNTER_BITS{1'b0}};
      run_seen_r   <= 1'b0;
      settle_cnt_r <= {SCW{1'b0}};
      res_valid_r  <= 1'b0;
      res_bypass_r <= 1'b0;
      res_last_r   <= 1'b0;
      res_bit_r    <= {BSW{1'b0}};
      res_count_r  <= {RING_OSC_COUNTER_BITS{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      step_byp_r   <= step_byp_nxt_s;
      step_bit_r   <= step_bit_nxt_s;
      run_seen_r   <= (state_r == ST_RUN);
      settle_cnt_r <= (state_r == ST_SETTLE) ? settle_cnt_r + SCW'(1) : {SCW{1'b0}};
      res_valid_r  <= (state_nxt_s == ST_EMIT);
      if ((state_r == ST_IDLE) && accept_s) begin
        sweep_r      <= sweep;
        cal_r        <= cal;
        bit_sel_r    <= bit_sel;
        integ_time_r <= integ_time;
      end
      if ((state_r == ST_SETTLE) && (state_nxt_s == ST_EMIT)) begin
        res_count_r  <= ring_osc_counter;
        res_bypass_r <= step_byp_r;
        res_bit_r    <= step_byp_r ? {BSW{1'b0}} : step_bit_r;
        res_last_r   <= is_last_s;
      end
    end
  end

  // adder-facing controls registered from the upcoming state so they align with it
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      adder_reset_r    <= 1'b1;
      stop_b_r         <= 1'b0;
      bypass_b_r       <= 1'b1;
      counter_load_r   <= 1'b0;
      counter_enable_r <= 1'b0;
      a_vec_r          <= {WIDTH{1'b1}};
      s_vec_r          <= {WIDTH{1'b1}};
      busy_r           <= 1'b0;
      err_r            <= 1'b0;
    end else begin
      adder_reset_r    <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_CLEAR);
      stop_b_r         <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_RUN);
      bypass_b_r       <= !(active_nxt_s && step_byp_nxt_s);
      counter_load_r   <= (state_nxt_s == ST_LOAD);
      counter_enable_r <= (state_nxt_s == ST_RUN);
      a_vec_r          <= a_vec_s;
      s_vec_r          <= s_vec_s;
      busy_r           <= (state_nxt_s != ST_IDLE);
      err_r            <= (state_r == ST_IDLE) && start && !accept_s;
    end
  end

  assign adder_reset        = adder_reset_r;
  assign stop_b             = stop_b_r;
  assign bypass_b           = bypass_b_r;
  assign counter_load       = counter_load_r;
  assign counter_enable     = counter_enable_r;
  assign a_input_ring_bit_b = a_vec_r;
  assign s_output_bit_b     = s_vec_r;
  assign busy               = busy_r;
  assign err                = err_r;
  assign res.res_valid      = res_valid_r;
  assign res.res_bypass     = res_bypass_r;
  assign res.res_bit        = res_bit_r;
  assign res.res_count      = res_count_r;
  assign res.res_last       = res_last_r;
endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer with a small adder timer model.
module tb_adder_measure_sequencer;
  logic        clk = 1'b0;
  logic        reset_b, start, abort, sweep, cal, done, done_force, start2;
  logic [2:0]  bit_sel, bit_sel2;
  logic [31:0] integ_time, ring, en_cnt;
  logic        adder_reset, stop_b, bypass_b, counter_load, counter_enable, busy, err;
  logic [7:0]  a_vec, s_vec;
  logic        adder_reset2, stop_b2, bypass_b2, counter_load2, counter_enable2, busy2, err2;
  logic [5:0]  a_vec2, s_vec2;
  int          vec_cnt = 0;
  int          miss_cnt = 0;

  adder_measure_sequencer_if #(.WIDTH(8), .RING_OSC_COUNTER_BITS(32)) ri ();
  adder_measure_sequencer_if #(.WIDTH(6), .RING_OSC_COUNTER_BITS(32)) ri2 ();

  adder_measure_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .reset_b(reset_b), .start(start), .abort(abort), .sweep(sweep), .cal(cal),
    .bit_sel(bit_sel), .integ_time(integ_time), .adder_reset(adder_reset), .stop_b(stop_b),
    .bypass_b(bypass_b), .counter_load(counter_load), .counter_enable(counter_enable),
    .a_input_ring_bit_b(a_vec), .s_output_bit_b(s_vec), .done(done),
    .ring_osc_counter(ring), .res(ri.master), .busy(busy), .err(err)
  );

  adder_measure_sequencer #(.WIDTH(6)) dut6 (
    .clk(clk), .reset_b(reset_b), .start(start2), .abort(abort), .sweep(sweep), .cal(cal),
    .bit_sel(bit_sel2), .integ_time(integ_time), .adder_reset(adder_reset2), .stop_b(stop_b2),
    .bypass_b(bypass_b2), .counter_load(counter_load2), .counter_enable(counter_enable2),
    .a_input_ring_bit_b(a_vec2), .s_output_bit_b(s_vec2), .done(1'b1),
    .ring_osc_counter(32'd0), .res(ri2.master), .busy(busy2), .err(err2)
  );

  always #5 clk = ~clk;

  // adder integration timer: cleared by counter_load, counts enabled cycles
  always @(posedge clk) begin
    if (counter_load) en_cnt <= 32'd0;
    else if (counter_enable) en_cnt <= en_cnt + 32'd1;
  end
  assign done = done_force || (en_cnt >= integ_time);

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_run(input logic s, input logic c, input logic [2:0] b, input logic [31:0] t);
    @(negedge clk);
    sweep = s; cal = c; bit_sel = b; integ_time = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    @(negedge clk);
    while (!ri.res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, ri.res_valid, 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_adder_reset"}, adder_reset, 1);
    check_eq({tag, "_stop_b"}, stop_b, 0);
    check_eq({tag, "_bypass_b"}, bypass_b, 1);
    check_eq({tag, "_load"}, counter_load, 0);
    check_eq({tag, "_enable"}, counter_enable, 0);
    check_eq({tag, "_a_vec"}, a_vec, 8'hFF);
    check_eq({tag, "_s_vec"}, s_vec, 8'hFF);
    check_eq({tag, "_res_valid"}, ri.res_valid, 0);
    check_eq({tag, "_res_count"}, ri.res_count, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_b = 1'b0; start = 1'b0; start2 = 1'b0; abort = 1'b0; sweep = 1'b0; cal = 1'b0;
    bit_sel = 3'd0; bit_sel2 = 3'd0; integ_time = 32'd0; ring = 32'd123; en_cnt = 32'd0;
    done_force = 1'b0; ri.res_ready = 1'b0; ri2.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("rst");
    reset_b = 1'b1;

    // single bit 3
    start_run(1'b0, 1'b0, 3'd3, 32'd10);
    check_eq("t1_clear_rst", adder_reset, 1);
    check_eq("t1_clear_a", a_vec, 8'hF7);
    check_eq("t1_clear_busy", busy, 1);
    @(negedge clk);
    check_eq("t1_load", counter_load, 1);
    check_eq("t1_load_stop", stop_b, 1);
    check_eq("t1_load_rst", adder_reset, 0);
    @(negedge clk);
    check_eq("t1_run_en", counter_enable, 1);
    check_eq("t1_run_a", a_vec, 8'hF7);
    check_eq("t1_run_s", s_vec, 8'hF7);
    check_eq("t1_run_byp", bypass_b, 1);
    wait_valid("t1");
    check_eq("t1_bit", ri.res_bit, 3);
    check_eq("t1_count", ri.res_count, 123);
    check_eq("t1_last", ri.res_last, 1);
    check_eq("t1_bypass", ri.res_bypass, 0);
    check_eq("t1_emit_stop", stop_b, 0);
    check_eq("t1_emit_s", s_vec, 8'hFF);
    ri.res_ready = 1'b1;
    @(negedge clk);
    check_eq("t1_hs_valid", ri.res_valid, 0);
    check_eq("t1_hs_busy", busy, 0);
    ri.res_ready = 1'b0;

    // cal + bit 5, done held high, backpressure on the bypass result
    ring = 32'h55; done_force = 1'b1;
    start_run(1'b0, 1'b1, 3'd5, 32'd10);
    check_eq("t2_clear_byp", bypass_b, 0);
    check_eq("t2_clear_a", a_vec, 8'hFF);
    check_eq("t2_clear_s", s_vec, 8'hFF);
    repeat (3) @(negedge clk);
    check_eq("t2_run2_en", counter_enable, 1);
    @(negedge clk);
    check_eq("t2_settle_en", counter_enable, 0);
    check_eq("t2_settle_stop", stop_b, 0);
    wait_valid("t2a");
    check_eq("t2a_bypass", ri.res_bypass, 1);
    check_eq("t2a_bit", ri.res_bit, 0);
    check_eq("t2a_last", ri.res_last, 0);
    check_eq("t2a_count", ri.res_count, 32'h55);
    check_eq("t2a_emit_byp", bypass_b, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("t2_bp_valid", ri.res_valid, 1);
      check_eq("t2_bp_noclear", adder_reset, 0);
    end
    ri.res_ready = 1'b1;
    @(negedge clk);
    ri.res_ready = 1'b0;
    check_eq("t2b_clear_a", a_vec, 8'hDF);
    check_eq("t2b_clear_byp", bypass_b, 1);
    wait_valid("t2b");
    check_eq("t2b_bit", ri.res_bit, 5);
    check_eq("t2b_last", ri.res_last, 1);
    check_eq("t2b_bypass", ri.res_bypass, 0);
    ri.res_ready = 1'b1;
    @(negedge clk);
    check_eq("t2_end_busy", busy, 0);
    done_force = 1'b0;

    // sweep with calibration: bypass then bits 0..7
    ring = 32'hBEEF;
    start_run(1'b1, 1'b1, 3'd0, 32'd3);
    for (int k = 0; k < 9; k++) begin
      wait_valid("t3");
      check_eq("t3_bypass", ri.res_bypass, (k == 0) ? 1 : 0);
      check_eq("t3_bit", ri.res_bit, (k == 0) ? 0 : k - 1);
      check_eq("t3_last", ri.res_last, (k == 8) ? 1 : 0);
      check_eq("t3_count", ri.res_count, 32'hBEEF);
    end
    @(negedge clk);
    check_eq("t3_end_busy", busy, 0);
    ri.res_ready = 1'b0;

    // abort during RUN
    start_run(1'b0, 1'b0, 3'd2, 32'd50);
    repeat (2) @(negedge clk);
    check_eq("t4_run_en", counter_enable, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t4_busy", busy, 0);
    check_eq("t4_stop", stop_b, 0);
    check_eq("t4_en", counter_enable, 0);
    check_eq("t4_a", a_vec, 8'hFF);
    repeat (15) @(negedge clk);
    check_eq("t4_no_valid", ri.res_valid, 0);

    // rejected starts
    start_run(1'b0, 1'b0, 3'd3, 32'd0);
    check_eq("t5_err_t0", err, 1);
    check_eq("t5_busy_t0", busy, 0);
    @(negedge clk);
    check_eq("t5_err_pulse", err, 0);
    check_eq("t5_busy_t0b", busy, 0);
    integ_time = 32'd5; sweep = 1'b0; bit_sel2 = 3'd6; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check_eq("t5_err_sel", err2, 1);
    check_eq("t5_busy_sel", busy2, 0);
    @(negedge clk);
    check_eq("t5_err_sel_pulse", err2, 0);
    sweep = 1'b1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check_eq("t5_sweep_ok_busy", busy2, 1);
    check_eq("t5_sweep_ok_err", err2, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_eq("t5_abort_busy", busy2, 0);

    // reset during SETTLE, then a normal run
    ring = 32'd77;
    start_run(1'b0, 1'b0, 3'd0, 32'd2);
    for (int n = 0; n < 20 && !counter_enable; n++) @(negedge clk);
    for (int n = 0; n < 50 && counter_enable; n++) @(negedge clk);
    check_eq("t6_in_settle", busy, 1);
    reset_b = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    check_reset_state("t6");
    repeat (8) @(negedge clk);
    check_eq("t6_no_valid", ri.res_valid, 0);
    start_run(1'b0, 1'b0, 3'd7, 32'd4);
    check_eq("t6_clear_s", s_vec, 8'h7F);
    wait_valid("t6");
    check_eq("t6_bit", ri.res_bit, 7);
    check_eq("t6_count", ri.res_count, 77);
    check_eq("t6_last", ri.res_last, 1);
    ri.res_ready = 1'b1;
    @(negedge clk);
    check_eq("t6_end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule
